// File: rtl/pat_gen.sv
// rtl/pat_gen.sv - address/data pattern generator with valid/ready handshake
//
// Sweeps addresses 0..DEPTH-1 once per run and presents one data word per
// address in the selected pattern (INC, ONES, WALK1, Galois LFSR).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   dft_tm_i       test mode, 1 freezes all state
//   pg_en_i        level-sensitive run request; low aborts / leaves DONE
//   pg_mode_i      pattern select, latched at run start
//   pg_rdy_i       consumer ready
//   pg_dt_valid_o  beat valid
//   pg_addr_o      beat address
//   pg_dt_o        beat data
//   pg_done_o      run complete, held until pg_en_i drops
module pat_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(8'hB8),
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED = DATA_WIDTH'(8'h01)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dft_tm_i,
    input  logic                  pg_en_i,
    input  logic [1:0]            pg_mode_i,
    input  logic                  pg_rdy_i,
    output logic                  pg_dt_valid_o,
    output logic [ADDR_WIDTH-1:0] pg_addr_o,
    output logic [DATA_WIDTH-1:0] pg_dt_o,
    output logic                  pg_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_ONES  = 2'd1;
    localparam logic [1:0] MODE_WALK1 = 2'd2;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [DATA_WIDTH-1:0] SEED =
        (LFSR_SEED == '0) ? DATA_WIDTH'(1) : LFSR_SEED;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(
        input logic [DATA_WIDTH-1:0] s
    );
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // lfsr is the LFSR state belonging to beat n; only used in LFSR mode.
    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [1:0]            mode,
        input logic [ADDR_WIDTH-1:0] n,
        input logic [DATA_WIDTH-1:0] lfsr
    );
        logic [DATA_WIDTH-1:0] one;
        int unsigned           bit_idx;
        one     = DATA_WIDTH'(1);
        bit_idx = 32'(n) % DATA_WIDTH;
        case (mode)
            MODE_INC:   return DATA_WIDTH'(n);
            MODE_ONES:  return '1;
            MODE_WALK1: return one << bit_idx;
            default:    return lfsr;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nx;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INC;
            lfsr_q  <= SEED;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        lfsr_d   = lfsr_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        lfsr_nx  = lfsr_step(lfsr_q);
        addr_inc = addr_q + ADDR_WIDTH'(1);

        if (!dft_tm_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (pg_en_i) begin
                        state_d = ST_RUN;
                        mode_d  = pg_mode_i;
                        lfsr_d  = SEED;
                        valid_d = 1'b1;
                        addr_d  = '0;
                        data_d  = pattern(pg_mode_i, '0, SEED);
                    end
                end
                ST_RUN: begin
                    // Abort takes priority over any transfer at the same edge,
                    // including the final one.
                    if (!pg_en_i) begin
                        state_d = ST_IDLE;
                        lfsr_d  = SEED;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        done_d  = 1'b0;
                    end else if (pg_rdy_i) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr_inc;
                            lfsr_d = lfsr_nx;
                            data_d = pattern(mode_q, addr_inc, lfsr_nx);
                        end
                    end
                end
                ST_DONE: begin
                    if (!pg_en_i) begin
                        state_d = ST_IDLE;
                        lfsr_d  = SEED;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    lfsr_d  = SEED;
                    valid_d = 1'b0;
                    addr_d  = '0;
                    data_d  = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign pg_dt_valid_o = valid_q;
    assign pg_addr_o     = addr_q;
    assign pg_dt_o       = data_q;
    assign pg_done_o     = done_q;

endmodule

// File: tb/tb_pat_gen.sv
// tb/tb_pat_gen.sv - self-checking bench for pat_gen (DEPTH=4 and DEPTH=256 instances)
module tb_pat_gen;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       dft_tm_i = 1'b0;
    logic       pg_en_i = 1'b0;
    logic [1:0] pg_mode_i = 2'd0;
    logic       pg_rdy_i = 1'b1;

    logic       a_valid, b_valid, a_done, b_done;
    logic [7:0] a_addr, b_addr, a_data, b_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    pat_gen #(.DEPTH(4)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .dft_tm_i(dft_tm_i), .pg_en_i(pg_en_i),
        .pg_mode_i(pg_mode_i), .pg_rdy_i(pg_rdy_i), .pg_dt_valid_o(a_valid),
        .pg_addr_o(a_addr), .pg_dt_o(a_data), .pg_done_o(a_done)
    );

    pat_gen dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .dft_tm_i(dft_tm_i), .pg_en_i(pg_en_i),
        .pg_mode_i(pg_mode_i), .pg_rdy_i(pg_rdy_i), .pg_dt_valid_o(b_valid),
        .pg_addr_o(b_addr), .pg_dt_o(b_data), .pg_done_o(b_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dep(input int i);
        return (i == 0) ? 4 : 256;
    endfunction

    // Data word for beat n, computed from scratch each time.
    function automatic logic [7:0] pat_ref(input logic [1:0] mode, input int n);
        logic [7:0] s;
        case (mode)
            2'd0: return 8'(n);
            2'd1: return 8'hFF;
            2'd2: return 8'(1 << (n % 8));
            default: begin
                s = 8'h01;
                for (int k = 0; k < n; k++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
                return s;
            end
        endcase
    endfunction

    // phase: 0 idle, 1 running (beat m_n on offer), 2 finished
    int         m_ph [2];
    int         m_n  [2];
    logic [1:0] m_mode [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_n[i] = 0; m_mode[i] = 2'd0;
        end
    end

    always @(posedge clk_i or posedge rst_i) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_i) begin
                m_ph[i] = 0; m_n[i] = 0; m_mode[i] = 2'd0;
            end else if (!dft_tm_i) begin
                if (m_ph[i] == 0) begin
                    if (pg_en_i) begin m_ph[i] = 1; m_n[i] = 0; m_mode[i] = pg_mode_i; end
                end else if (!pg_en_i) begin
                    m_ph[i] = 0;
                end else if (m_ph[i] == 1 && pg_rdy_i) begin
                    if (m_n[i] == dep(i) - 1) m_ph[i] = 2;
                    else m_n[i] = m_n[i] + 1;
                end
            end
        end
    end

    logic       d_valid [2];
    logic       d_done  [2];
    logic [7:0] d_addr  [2];
    logic [7:0] d_data  [2];
    assign d_valid[0] = a_valid; assign d_valid[1] = b_valid;
    assign d_done[0]  = a_done;  assign d_done[1]  = b_done;
    assign d_addr[0]  = a_addr;  assign d_addr[1]  = b_addr;
    assign d_data[0]  = a_data;  assign d_data[1]  = b_data;

    // Every-cycle comparison against the model.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d_valid", i), 32'(d_valid[i]), 32'(m_ph[i] == 1));
                chk($sformatf("dut%0d_done", i), 32'(d_done[i]), 32'(m_ph[i] == 2));
                chk($sformatf("dut%0d_addr", i), 32'(d_addr[i]),
                    (m_ph[i] == 0) ? 32'd0 : 32'(m_n[i]));
                chk($sformatf("dut%0d_data", i), 32'(d_data[i]),
                    (m_ph[i] == 0) ? 32'd0 : 32'(pat_ref(m_mode[i], m_n[i])));
            end
        end
    end

    // Accepted beats {addr,data}; inputs are stable from negedge to next posedge.
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    always @(negedge clk_i) begin
        if (!rst_i && !dft_tm_i && pg_rdy_i) begin
            if (a_valid) q_a.push_back({a_addr, a_data});
            if (b_valid) q_b.push_back({b_addr, b_data});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    logic [15:0] first_lfsr[$];
    logic [7:0]  d9, d7, held_addr, held_data;
    int          cnt, bad;

    initial begin
        cyc(3);
        rst_i = 1'b0;
        chk("reset_valid", 32'(b_valid), 32'd0);
        chk("reset_addr", 32'(b_addr), 32'd0);
        chk("reset_data", 32'(b_data), 32'd0);
        chk("reset_done", 32'(b_done), 32'd0);
        cyc(2);

        // INC on the DEPTH=4 instance
        q_a.delete();
        pg_mode_i = 2'd0; pg_rdy_i = 1'b1; pg_en_i = 1'b1;
        cyc(1);
        cyc(4);
        chk("inc_valid_drop", 32'(a_valid), 32'd0);
        chk("inc_done", 32'(a_done), 32'd1);
        chk("inc_beats", 32'(q_a.size()), 32'd4);
        if (q_a.size() == 4) begin
            chk("inc_b0", 32'(q_a[0]), 32'h0000);
            chk("inc_b1", 32'(q_a[1]), 32'h0101);
            chk("inc_b2", 32'(q_a[2]), 32'h0202);
            chk("inc_b3", 32'(q_a[3]), 32'h0303);
        end
        pg_en_i = 1'b0;
        cyc(1);
        chk("inc_done_clear", 32'(a_done), 32'd0);
        cyc(1);

        // ONES, full 256-beat run
        q_b.delete();
        pg_mode_i = 2'd1; pg_en_i = 1'b1;
        cnt = 0;
        while (!b_done && cnt < 400) begin cyc(1); cnt++; end
        chk("ones_done_timeout", 32'(b_done), 32'd1);
        chk("ones_beats", 32'(q_b.size()), 32'd256);
        bad = 0;
        foreach (q_b[k]) if (q_b[k][7:0] != 8'hFF || q_b[k][15:8] != 8'(k)) bad++;
        chk("ones_beat_content", 32'(bad), 32'd0);
        cyc(3);
        chk("ones_hold_addr", 32'(b_addr), 32'hFF);
        chk("ones_hold_data", 32'(b_data), 32'hFF);
        chk("ones_hold_done", 32'(b_done), 32'd1);
        pg_en_i = 1'b0;
        cyc(2);

        // WALK1 under alternating backpressure
        q_b.delete();
        pg_mode_i = 2'd2; pg_en_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pg_rdy_i = (i % 2 == 1);
            cyc(1);
            pg_mode_i = 2'($urandom_range(0, 3));
        end
        pg_rdy_i = 1'b1;
        d9 = 8'h00; d7 = 8'h00; bad = 0;
        foreach (q_b[k]) begin
            if (q_b[k][15:8] != 8'(k)) bad++;
            if (q_b[k][15:8] == 8'd9) d9 = q_b[k][7:0];
            if (q_b[k][15:8] == 8'd7) d7 = q_b[k][7:0];
        end
        chk("walk_addr_seq", 32'(bad), 32'd0);
        chk("walk_addr9", 32'(d9), 32'h02);
        chk("walk_addr7", 32'(d7), 32'h80);
        pg_en_i = 1'b0;
        cyc(2);

        // LFSR, run twice
        q_b.delete();
        pg_mode_i = 2'd3; pg_en_i = 1'b1;
        cyc(8);
        chk("lfsr_cnt", 32'(q_b.size() >= 5), 32'd1);
        if (q_b.size() >= 5) begin
            chk("lfsr_b0", 32'(q_b[0][7:0]), 32'h01);
            chk("lfsr_b1", 32'(q_b[1][7:0]), 32'hB8);
            chk("lfsr_b2", 32'(q_b[2][7:0]), 32'h5C);
            chk("lfsr_b3", 32'(q_b[3][7:0]), 32'h2E);
            chk("lfsr_b4", 32'(q_b[4][7:0]), 32'h17);
        end
        first_lfsr = q_b;
        pg_en_i = 1'b0;
        cyc(2);
        q_b.delete();
        pg_en_i = 1'b1;
        cyc(8);
        bad = 0;
        for (int k = 0; k < 5; k++)
            if (k >= q_b.size() || k >= first_lfsr.size() || q_b[k] != first_lfsr[k]) bad++;
        chk("lfsr_rerun", 32'(bad), 32'd0);
        pg_en_i = 1'b0;
        cyc(2);

        // Abort at addr 5
        pg_mode_i = 2'd2; pg_en_i = 1'b1;
        cnt = 0;
        while (b_addr != 8'd5 && cnt < 50) begin cyc(1); cnt++; end
        chk("abort_reach5", 32'(b_addr), 32'd5);
        pg_en_i = 1'b0;
        cyc(1);
        chk("abort_valid", 32'(b_valid), 32'd0);
        chk("abort_addr", 32'(b_addr), 32'd0);
        chk("abort_done", 32'(b_done), 32'd0);
        pg_en_i = 1'b1;
        cyc(1);
        chk("reen_valid", 32'(b_valid), 32'd1);
        chk("reen_addr", 32'(b_addr), 32'd0);
        chk("reen_data", 32'(b_data), 32'h01);
        pg_en_i = 1'b0;
        cyc(2);

        // Asynchronous reset between edges
        pg_mode_i = 2'd1; pg_en_i = 1'b1;
        cnt = 0;
        while (b_addr != 8'd3 && cnt < 50) begin cyc(1); cnt++; end
        chk("rst_reach3", 32'(b_addr), 32'd3);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_valid", 32'(b_valid), 32'd0);
        chk("arst_addr", 32'(b_addr), 32'd0);
        chk("arst_data", 32'(b_data), 32'd0);
        chk("arst_done", 32'(a_done), 32'd0);
        rst_i = 1'b0;
        cyc(1);
        chk("arst_restart_addr", 32'(b_addr), 32'd0);
        chk("arst_restart_valid", 32'(b_valid), 32'd1);

        // Test-mode freeze mid-run
        pg_mode_i = 2'd0;
        cyc(10);
        held_addr = b_addr; held_data = b_data;
        dft_tm_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pg_rdy_i = 1'(i % 2);
            cyc(1);
            chk("dft_addr_frozen", 32'(b_addr), 32'(held_addr));
            chk("dft_data_frozen", 32'(b_data), 32'(held_data));
        end
        dft_tm_i = 1'b0; pg_rdy_i = 1'b1;
        cnt = 0;
        while (!b_done && cnt < 400) begin cyc(1); cnt++; end
        chk("dft_run_completes", 32'(b_done), 32'd1);
        chk("dft_final_addr", 32'(b_addr), 32'hFF);
        pg_en_i = 1'b0;
        cyc(2);

        // Randomised traffic; the per-cycle compare does the checking
        for (int i = 0; i < 4000; i++) begin
            pg_en_i   = ($urandom_range(0, 39) != 0);
            pg_mode_i = 2'($urandom_range(0, 3));
            pg_rdy_i  = ($urandom_range(0, 3) != 0);
            dft_tm_i  = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        dft_tm_i = 1'b0; pg_en_i = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
